// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer/transmitter-side signals of the UART TX byte FIFO.
// Optional overflow signals exist only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_fWr;
    logic [7:0]        i_WrData;
    logic              o_fFull;
    logic              o_fEmpty;
    logic [ADDR_W:0]   o_Level;
    logic              o_fTx;
    logic [7:0]        o_TxData;
    logic              i_fTxReady;
    logic              i_fTxDone;
`ifdef UART_TX_FIFO_OVF_EN
    logic              o_fOverflow;
    logic              i_fClrOvf;

    modport slave (
        input  i_fWr, i_WrData, i_fTxReady, i_fTxDone, i_fClrOvf,
        output o_fFull, o_fEmpty, o_Level, o_fTx, o_TxData, o_fOverflow
    );
    modport master (
        output i_fWr, i_WrData, i_fTxReady, i_fTxDone, i_fClrOvf,
        input  o_fFull, o_fEmpty, o_Level, o_fTx, o_TxData, o_fOverflow
    );
`else
    modport slave (
        input  i_fWr, i_WrData, i_fTxReady, i_fTxDone,
        output o_fFull, o_fEmpty, o_Level, o_fTx, o_TxData
    );
    modport master (
        output i_fWr, i_WrData, i_fTxReady, i_fTxDone,
        input  o_fFull, o_fEmpty, o_Level, o_fTx, o_TxData
    );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter, one frame at a
// time. Strobes o_fTx for one cycle per byte, then waits for frame-done.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    uart_tx_fifo_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      tx_data;
    logic            empty, full, pop, wr_accept;

    // Occupancy flags come straight from the registered pointers; the wrap
    // bit distinguishes full from empty when the address bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    // A full FIFO still takes a write when a slot frees up on the same edge.
    assign wr_accept = bus.i_fWr && (!full || pop);

    assign bus.o_fEmpty = empty;
    assign bus.o_fFull  = full;
    assign bus.o_Level  = wr_ptr - rd_ptr;
    assign bus.o_TxData = tx_data;
    // Strobe decoded from state so reset drops it without waiting for a clock.
    assign bus.o_fTx    = (state == ISSUE);

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and dequeue decision; ready is only consulted in IDLE.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && bus.i_fTxReady) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.i_fTxDone) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Pointers and the transmit data register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tx_data <= 8'h00;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_Clk) begin
        if (wr_accept) mem[wr_ptr[ADDR_W-1:0]] <= bus.i_WrData;
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf;
    assign bus.o_fOverflow = ovf;

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)                        ovf <= 1'b0;
        else if (bus.i_fWr && full && !pop) ovf <= 1'b1;
        else if (bus.i_fClrOvf)           ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the UART TX FIFO with a simple
// transmitter model that returns frame-done 10 cycles after each strobe.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic       auto_tx   = 1'b0;
    logic       man_done  = 1'b0;
    logic       done_auto;
    int         timer;
    logic [7:0] sq [$];
    int         sc [$];

    assign bus.i_fTxDone = done_auto | man_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: frame-done pulse a fixed time after each strobe.
    always @(negedge clk) begin
        if (rst) begin
            timer     <= 0;
            done_auto <= 1'b0;
        end else begin
            done_auto <= (timer == 1);
            if (auto_tx && bus.o_fTx) timer <= 10;
            else if (timer != 0)      timer <= timer - 1;
        end
    end

    // Strobe monitor: record every byte handed to the transmitter.
    always @(negedge clk) begin
        if (bus.o_fTx) begin
            sq.push_back(bus.o_TxData);
            sc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.i_fWr    = 1'b1;
        bus.i_WrData = d;
        tick();
        bus.i_fWr    = 1'b0;
    endtask

    initial begin
        int wc;
        bus.i_fWr      = 1'b0;
        bus.i_WrData   = 8'h00;
        bus.i_fTxReady = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
        bus.i_fClrOvf  = 1'b0;
`endif
        tick(3);
        rst = 1'b0;

        // Idle after reset: nothing to send.
        tick(50);
        chk("rst_empty", bus.o_fEmpty, 1);
        chk("rst_full", bus.o_fFull, 0);
        chk("rst_level", bus.o_Level, 0);
        chk("rst_txdata", bus.o_TxData, 8'h00);
        chk("rst_nostrobe", sq.size(), 0);

        // Single byte: strobe one cycle after the write edge, then stall.
        wr(8'hA5);
        wc = cyc;
        chk("one_empty", bus.o_fEmpty, 0);
        tick(15);
        chk("one_count", sq.size(), 1);
        chk("one_data", sq[0], 8'hA5);
        chk("one_cycle", sc[0], wc + 1);
        chk("one_hold", bus.o_TxData, 8'hA5);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick(3);
        chk("one_nosecond", sq.size(), 1);

        // Three bytes with the transmitter model answering.
        sq.delete(); sc.delete();
        auto_tx = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        tick(60);
        chk("three_count", sq.size(), 3);
        chk("three_b0", sq[0], 8'h11);
        chk("three_b1", sq[1], 8'h22);
        chk("three_b2", sq[2], 8'h33);
        chk("three_gap1", sc[1] - sc[0], 12);
        chk("three_gap2", sc[2] - sc[1], 12);
        chk("three_level", bus.o_Level, 0);

        // Overfill with the transmitter busy; two bytes are dropped.
        sq.delete(); sc.delete();
        bus.i_fTxReady = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr(8'(i));
            if (i == 15) begin
                chk("fill_full16", bus.o_fFull, 1);
                chk("fill_level16", bus.o_Level, 16);
            end
        end
        chk("ovr_level", bus.o_Level, 16);
        chk("ovr_full", bus.o_fFull, 1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovr_flag", bus.o_fOverflow, 1);
        bus.i_fClrOvf = 1'b1;
        tick();
        bus.i_fClrOvf = 1'b0;
        chk("ovr_clr", bus.o_fOverflow, 0);
`endif
        bus.i_fTxReady = 1'b1;
        tick(16 * 12 + 20);
        chk("drain_count", sq.size(), 16);
        for (int i = 0; i < 16 && i < sq.size(); i++)
            chk($sformatf("drain_b%0d", i), sq[i], 8'(i));
        chk("drain_empty", bus.o_fEmpty, 1);

        // Write into a full FIFO on the same edge as a pop.
        sq.delete(); sc.delete();
        bus.i_fTxReady = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
        chk("wp_full", bus.o_fFull, 1);
        bus.i_fTxReady = 1'b1;
        wr(8'h5A);
        chk("wp_level", bus.o_Level, 16);
        tick(17 * 12 + 20);
        chk("wp_count", sq.size(), 17);
        chk("wp_first", sq[0], 8'h80);
        chk("wp_16th", sq[15], 8'h8F);
        chk("wp_17th", sq[16], 8'h5A);

        // Reset while waiting for frame-done with bytes queued.
        sq.delete(); sc.delete();
        auto_tx = 1'b0;
        bus.i_fTxReady = 1'b0;
        for (int i = 1; i <= 5; i++) wr(8'(i));
        bus.i_fTxReady = 1'b1;
        tick(5);
        chk("mr_strobe", sq.size(), 1);
        chk("mr_level", bus.o_Level, 4);
        #3 rst = 1'b1;
        #1;
        chk("mr_rst_level", bus.o_Level, 0);
        chk("mr_rst_empty", bus.o_fEmpty, 1);
        chk("mr_rst_tx", bus.o_fTx, 0);
        chk("mr_rst_data", bus.o_TxData, 8'h00);
        tick(2);
        rst = 1'b0;
        sq.delete(); sc.delete();
        tick(30);
        chk("mr_quiet", sq.size(), 0);
        wr(8'h77);
        tick(5);
        chk("mr_new_count", sq.size(), 1);
        chk("mr_new_data", sq[0], 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
